// File: rtl/fifo_sync_prog.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_prog
// Purpose  : Single-clock FIFO with run-time almost-full/almost-empty
//            thresholds, occupancy count and selectable FWFT read mode.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_prog #(
    parameter int  FIFO_WIDTH = 16,
    parameter int  FIFO_DEPTH = 8,
    parameter int  FWFT       = 0,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_thr,
    input  logic [CNT_W-1:0]      ae_thr,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // Acceptance uses the pre-edge occupancy, so a full FIFO rejects a write
    // even when a simultaneous read frees a slot (and vice versa when empty).
    assign w_full      = (r_count == C_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = wr_en & ~w_full;
    assign w_rd_accept = rd_en & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_wr_accept && !w_rd_accept) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_accept && !w_wr_accept) begin
                r_count <= r_count - 1'b1;
            end
            r_wr_ack    <= w_wr_accept;
            r_overflow  <= wr_en & w_full;
            r_underflow <= rd_en & w_empty;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] r_data_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_out <= '0;
                end else if (w_rd_accept) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= af_thr);
    assign almostempty = (r_count <= ae_thr);
    assign count       = r_count;

endmodule

`default_nettype wire
